// File: rtl/decode_operand_stage.sv
// Decode-stage operand issue: regfile read, pending-write scoreboard, RAW stall, output register.
// Optional feature macro DECODE_OPSTG_BYPASS_EN forwards same-cycle writeback data into operands.
module decode_operand_stage #(
  parameter int REGS_PTR_W = 5,
  parameter int REGS_NUM   = 32,
  parameter int REG_SIZE   = 32,
  parameter int CNT_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [REG_SIZE-1:0]       in_instr,
  input  logic [REG_SIZE-1:0]       in_pc,
  output logic [REGS_PTR_W-1:0]     rf_rs1,
  output logic [REGS_PTR_W-1:0]     rf_rs2,
  input  logic [REG_SIZE-1:0]       rf_rd1,
  input  logic [REG_SIZE-1:0]       rf_rd2,
  input  logic                      wb_we,
  input  logic [REGS_PTR_W-1:0]     wb_wa,
  input  logic [REG_SIZE-1:0]       wb_wd,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [REG_SIZE-1:0]       out_instr,
  output logic [REG_SIZE-1:0]       out_pc,
  output logic [REG_SIZE-1:0]       out_op1,
  output logic [REG_SIZE-1:0]       out_op2,
  output logic [REGS_PTR_W-1:0]     out_rd,
  output logic                      out_rd_we,
  output logic [REGS_NUM*CNT_W-1:0] dbg_pend
);
  // Handshake: a transfer happens on a cycle where valid && ready; valid never depends on ready,
  // and once out_vld is raised the out_* payload is held stable until out_rdy is seen.
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [6:0]       OPC_STORE  = 7'b0100011;
  localparam logic [6:0]       OPC_BRANCH = 7'b1100011;

  logic [REGS_PTR_W-1:0] rs1, rs2, rd;
  logic                  rd_we, haz_rs1, haz_rs2, haz_rd, hazard, accept;
  logic                  byp1, byp2;
  logic [REG_SIZE-1:0]   op1, op2;
  logic [REGS_NUM-1:0]   inc_vec, dec_vec;
  logic [CNT_W-1:0]      pend_q [REGS_NUM];
  logic [CNT_W-1:0]      pend_d [REGS_NUM];

  logic                  out_vld_q, out_vld_d, out_rd_we_q, out_rd_we_d;
  logic [REG_SIZE-1:0]   out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic [REG_SIZE-1:0]   out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [REGS_PTR_W-1:0] out_rd_q, out_rd_d;

  assign rs1    = REGS_PTR_W'(in_instr[19:15]);
  assign rs2    = REGS_PTR_W'(in_instr[24:20]);
  assign rd     = REGS_PTR_W'(in_instr[11:7]);
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;
  assign rd_we  = (in_instr[6:0] != OPC_STORE) && (in_instr[6:0] != OPC_BRANCH) && (rd != '0);

  assign byp1 = wb_we && (wb_wa == rs1);
  assign byp2 = wb_we && (wb_wa == rs2);

`ifdef DECODE_OPSTG_BYPASS_EN
  // One outstanding write that retires this cycle is covered by the forward path.
  assign haz_rs1 = (rs1 != '0) && ((pend_q[rs1] > CNT_ONE) || ((pend_q[rs1] == CNT_ONE) && !byp1));
  assign haz_rs2 = (rs2 != '0) && ((pend_q[rs2] > CNT_ONE) || ((pend_q[rs2] == CNT_ONE) && !byp2));
  assign op1 = (rs1 == '0) ? '0 : (byp1 ? wb_wd : rf_rd1);
  assign op2 = (rs2 == '0) ? '0 : (byp2 ? wb_wd : rf_rd2);
`else
  logic wb_wd_unused;
  assign wb_wd_unused = ^{wb_wd, byp1, byp2};
  assign haz_rs1 = (rs1 != '0) && (pend_q[rs1] != '0);
  assign haz_rs2 = (rs2 != '0) && (pend_q[rs2] != '0);
  assign op1 = (rs1 == '0) ? '0 : rf_rd1;
  assign op2 = (rs2 == '0) ? '0 : rf_rd2;
`endif

  assign haz_rd = rd_we && (pend_q[rd] == CNT_MAX);
  assign hazard = haz_rs1 || haz_rs2 || haz_rd;
  assign in_rdy = rst_n && !flush && (!out_vld_q || out_rdy) && !hazard;
  assign accept = in_vld && in_rdy;

  // Register 0 is never tracked; a decrement with nothing pending is dropped.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < REGS_NUM; r++) begin
      pend_d[r] = '0;
      if (r != 0) begin
        inc_vec[r] = accept && rd_we && (rd == REGS_PTR_W'(r));
        dec_vec[r] = wb_we && (wb_wa == REGS_PTR_W'(r)) && (pend_q[r] != '0);
        pend_d[r]  = pend_q[r];
        if (flush)                        pend_d[r] = '0;
        else if (inc_vec[r] && !dec_vec[r]) pend_d[r] = pend_q[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r]) pend_d[r] = pend_q[r] - CNT_ONE;
      end
    end
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    if (flush) begin
      out_vld_d = 1'b0;
    end else if (accept) begin
      out_vld_d   = 1'b1;
      out_instr_d = in_instr;
      out_pc_d    = in_pc;
      out_op1_d   = op1;
      out_op2_d   = op2;
      out_rd_d    = rd;
      out_rd_we_d = rd_we;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REGS_NUM; r++) pend_q[r] <= '0;
      out_vld_q   <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else begin
      for (int r = 0; r < REGS_NUM; r++) pend_q[r] <= pend_d[r];
      out_vld_q   <= out_vld_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
    end
  end

  always_comb begin
    dbg_pend = '0;
    for (int r = 0; r < REGS_NUM; r++) dbg_pend[r*CNT_W +: CNT_W] = pend_q[r];
  end

  assign out_vld   = out_vld_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage; expectations adapt to DECODE_OPSTG_BYPASS_EN.
module tb_decode_operand_stage;
  logic        clk, rst_n, flush, in_vld, in_rdy;
  logic [31:0] in_instr, in_pc, rf_rd1, rf_rd2, wb_wd;
  logic [4:0]  rf_rs1, rf_rs2, wb_wa, out_rd;
  logic        wb_we, out_vld, out_rdy, out_rd_we;
  logic [31:0] out_instr, out_pc, out_op1, out_op2;
  logic [63:0] dbg_pend;

  logic [31:0] rf_regs [32];
  logic [31:0] rf_x0_val;
  int tests_run, tests_failed;

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] ADDI_X3_1  = 32'h0010_0193;
  localparam logic [31:0] ADD_X4_X3  = 32'h0001_8233;
  localparam logic [31:0] ADDI_X5_1  = 32'h0010_0293;
  localparam logic [31:0] ADD_X6_X5  = 32'h0002_8333;
  localparam logic [31:0] ADDI_X7_1  = 32'h0010_0393;
  localparam logic [31:0] ADD_X8_X0  = 32'h0000_0433;
  localparam logic [31:0] ADDI_X9_9  = 32'h0090_0493;
  localparam logic [31:0] ADDI_X10_1 = 32'h0010_0513;
  localparam logic [31:0] SW_X1_X2   = 32'h0011_2423;

  decode_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_instr(out_instr), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .dbg_pend(dbg_pend)
  );

  // clock/reset block and regfile model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_regs[i] <= 32'h0;
    end else if (wb_we) begin
      rf_regs[wb_wa] <= wb_wd;
    end
  end
  assign rf_rd1 = (rf_rs1 == 5'd0) ? rf_x0_val : rf_regs[rf_rs1];
  assign rf_rd2 = (rf_rs2 == 5'd0) ? rf_x0_val : rf_regs[rf_rs2];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    int n;
    in_vld = 1'b1; in_instr = instr; in_pc = pc; n = 0;
    @(negedge clk);
    while (!in_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (in_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_timeout pc=%h: in_rdy=%b required 1", pc, in_rdy);
    end
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    wb_we = 1'b1; wb_wa = wa; wb_wd = wd;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
    tests_run++;
    if ({out_vld, out_pc, out_op1, out_instr} !== 97'h0) begin
      tests_failed++; $display("FAIL reset_out: vld=%b pc=%h op1=%h instr=%h want 0", out_vld, out_pc, out_op1, out_instr);
    end
    tests_run++;
    if (dbg_pend !== 64'h0) begin tests_failed++; $display("FAIL reset_pend: got %h want 0", dbg_pend); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_release_rdy: got %b want 1", in_rdy); end
    tick();
  endtask

  task automatic test_basic_issue();
    issue(ADDI_X1_5, 32'h100);
    tests_run++;
    if (out_vld !== 1'b1 || out_pc !== 32'h100 || out_instr !== ADDI_X1_5) begin
      tests_failed++; $display("FAIL basic_out: vld=%b pc=%h instr=%h want 1/100/%h", out_vld, out_pc, out_instr, ADDI_X1_5);
    end
    tests_run++;
    if (out_op1 !== 32'h0 || out_rd !== 5'd1 || out_rd_we !== 1'b1) begin
      tests_failed++; $display("FAIL basic_fields: op1=%h rd=%0d rd_we=%b want 0/1/1", out_op1, out_rd, out_rd_we);
    end
    tests_run++;
    if (dbg_pend[2 +: 2] !== 2'd1) begin tests_failed++; $display("FAIL basic_pend1: got %0d want 1", dbg_pend[2 +: 2]); end
    wb(5'd1, 32'h5);
    tests_run++;
    if (dbg_pend[2 +: 2] !== 2'd0 || out_vld !== 1'b0) begin
      tests_failed++; $display("FAIL basic_retire: pend1=%0d vld=%b want 0/0", dbg_pend[2 +: 2], out_vld);
    end
  endtask

  task automatic test_bypass();
    issue(ADDI_X3_1, 32'h110);
    in_vld = 1'b1; in_instr = ADD_X4_X3; in_pc = 32'h114;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL raw_stall: in_rdy=%b want 0", in_rdy); end
    tick();
    wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'hDEAD;
    @(negedge clk);
`ifdef DECODE_OPSTG_BYPASS_EN
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL bypass_rdy_k: in_rdy=%b want 1", in_rdy); end
    tick();
    wb_we = 1'b0; in_vld = 1'b0;
`else
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL nobypass_rdy_k: in_rdy=%b want 0", in_rdy); end
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL nobypass_rdy_k1: in_rdy=%b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
`endif
    tests_run++;
    if (out_vld !== 1'b1 || out_op1 !== 32'hDEAD || out_op2 !== 32'h0 || out_rd !== 5'd4) begin
      tests_failed++; $display("FAIL raw_out: vld=%b op1=%h op2=%h rd=%0d want 1/dead/0/4", out_vld, out_op1, out_op2, out_rd);
    end
    tests_run++;
    if (dbg_pend[6 +: 2] !== 2'd0 || dbg_pend[8 +: 2] !== 2'd1) begin
      tests_failed++; $display("FAIL raw_pend: p3=%0d p4=%0d want 0/1", dbg_pend[6 +: 2], dbg_pend[8 +: 2]);
    end
    wb(5'd4, 32'h44);
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    issue(ADDI_X9_9, 32'h200);
    in_vld = 1'b1; in_instr = ADDI_X10_1; in_pc = 32'h204;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b1 || out_pc !== 32'h200 || out_instr !== ADDI_X9_9) begin
        tests_failed++; $display("FAIL stall_hold[%0d]: rdy=%b vld=%b pc=%h want 0/1/200", i, in_rdy, out_vld, out_pc);
      end
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL stall_release_rdy: got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (out_vld !== 1'b1 || out_pc !== 32'h204 || out_rd !== 5'd10) begin
      tests_failed++; $display("FAIL stall_release_out: vld=%b pc=%h rd=%0d want 1/204/10", out_vld, out_pc, out_rd);
    end
    wb(5'd9, 32'h9);
    wb(5'd10, 32'h1);
  endtask

  task automatic test_dest_hazard();
    for (int i = 0; i < 3; i++) issue(ADDI_X7_1, 32'h300 + 32'(i * 4));
    tests_run++;
    if (dbg_pend[14 +: 2] !== 2'd3) begin tests_failed++; $display("FAIL dest_pend_full: got %0d want 3", dbg_pend[14 +: 2]); end
    in_vld = 1'b1; in_instr = ADDI_X7_1; in_pc = 32'h30C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL dest_stall[%0d]: in_rdy=%b want 0", i, in_rdy); end
      tick();
    end
    wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h7;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL dest_stall_wb: in_rdy=%b want 0", in_rdy); end
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL dest_after_wb: in_rdy=%b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (dbg_pend[14 +: 2] !== 2'd3 || out_pc !== 32'h30C) begin
      tests_failed++; $display("FAIL dest_fourth: pend7=%0d pc=%h want 3/30c", dbg_pend[14 +: 2], out_pc);
    end
    repeat (3) wb(5'd7, 32'h7);
    tests_run++;
    if (dbg_pend[14 +: 2] !== 2'd0) begin tests_failed++; $display("FAIL dest_drain: got %0d want 0", dbg_pend[14 +: 2]); end
  endtask

  task automatic test_flush();
    issue(ADDI_X5_1, 32'h400);
    issue(ADDI_X5_1, 32'h404);
    tests_run++;
    if (dbg_pend[10 +: 2] !== 2'd2 || out_vld !== 1'b1) begin
      tests_failed++; $display("FAIL flush_setup: pend5=%0d vld=%b want 2/1", dbg_pend[10 +: 2], out_vld);
    end
    flush = 1'b1;
    in_vld = 1'b1; in_instr = ADDI_X1_5; in_pc = 32'h4F0;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL flush_rdy: got %b want 0", in_rdy); end
    tick();
    flush = 1'b0;
    tests_run++;
    if (out_vld !== 1'b0 || dbg_pend !== 64'h0) begin
      tests_failed++; $display("FAIL flush_clear: vld=%b pend=%h want 0/0", out_vld, dbg_pend);
    end
    in_instr = ADD_X6_X5; in_pc = 32'h408;
    @(negedge clk);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL flush_accept_rdy: got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    tests_run++;
    if (out_vld !== 1'b1 || out_rd !== 5'd6 || out_pc !== 32'h408) begin
      tests_failed++; $display("FAIL flush_accept_out: vld=%b rd=%0d pc=%h want 1/6/408", out_vld, out_rd, out_pc);
    end
    wb(5'd6, 32'h0);
  endtask

  task automatic test_x0_store();
    rf_x0_val = 32'h1234;
    issue(ADD_X8_X0, 32'h600);
    tests_run++;
    if (out_op1 !== 32'h0 || out_op2 !== 32'h0 || out_rd_we !== 1'b1) begin
      tests_failed++; $display("FAIL x0_force: op1=%h op2=%h rd_we=%b want 0/0/1", out_op1, out_op2, out_rd_we);
    end
    issue(SW_X1_X2, 32'h604);
    tests_run++;
    if (out_rd_we !== 1'b0 || out_rd !== 5'd8 || out_op2 !== 32'h5 || out_op1 !== 32'h0) begin
      tests_failed++; $display("FAIL store_fields: rd_we=%b rd=%0d op1=%h op2=%h want 0/8/0/5", out_rd_we, out_rd, out_op1, out_op2);
    end
    tests_run++;
    if (dbg_pend !== 64'h1_0000) begin tests_failed++; $display("FAIL store_pend: got %h want 10000", dbg_pend); end
    rf_x0_val = 32'h0;
    wb(5'd8, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq[0] = 32'h0010_0593; seq[1] = 32'h0010_0613; seq[2] = 32'h0010_0693;
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = seq[i]; in_pc = 32'h500 + 32'(i * 4);
      @(negedge clk);
      tests_run++;
      if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL b2b_rdy[%0d]: got %b want 1", i, in_rdy); end
      tick();
      tests_run++;
      if (out_vld !== 1'b1 || out_pc !== 32'h500 + 32'(i * 4) || out_rd !== 5'(11 + i)) begin
        tests_failed++; $display("FAIL b2b_out[%0d]: vld=%b pc=%h rd=%0d", i, out_vld, out_pc, out_rd);
      end
    end
    in_vld = 1'b0;
    wb(5'd11, 32'h1); wb(5'd12, 32'h1); wb(5'd13, 32'h1);
    tests_run++;
    if (dbg_pend !== 64'h0) begin tests_failed++; $display("FAIL b2b_drain: got %h want 0", dbg_pend); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0; out_rdy = 1'b1; rf_x0_val = 32'h0;
    test_reset();
    test_basic_issue();
    test_bypass();
    test_backpressure();
    test_dest_hazard();
    test_flush();
    test_x0_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
